// File: rtl/gcn_aggregate_argmax_pkg.sv
// rtl/gcn_aggregate_argmax_pkg.sv - shared constants, state enum and row types for the GCN aggregate/argmax stage
// Purpose: default widths/sizes, FSM states, row typedefs and small helpers.
// Ports: none (package).
package gcn_pkg;

  localparam int FEATURE_ROWS      = 6;
  localparam int WEIGHT_COLS       = 3;
  localparam int DOT_PROD_WIDTH    = 16;
  localparam int AGG_WIDTH         = DOT_PROD_WIDTH + 3;
  localparam int COO_NUM_OF_COLS   = 6;
  localparam int COO_BW            = $clog2(COO_NUM_OF_COLS);
  localparam int ROW_BW            = $clog2(FEATURE_ROWS);
  localparam int MAX_ADDRESS_WIDTH = 2;

  typedef enum logic [2:0] {IDLE, LOAD, EDGE, ARGMAX, DONE} state_t;

  typedef logic [0:WEIGHT_COLS-1][DOT_PROD_WIDTH-1:0] fm_wm_row_t;
  typedef logic [0:WEIGHT_COLS-1][AGG_WIDTH-1:0]      agg_row_t;
  typedef logic [0:1][COO_BW-1:0]                     coo_col_t;

  // COO node ids are 1-based; 0 and anything past the last node mark a dead edge.
  function automatic logic node_valid(input logic [COO_BW-1:0] n);
    return (n != '0) && (n <= COO_BW'(FEATURE_ROWS));
  endfunction

  // Element-wise accumulate; wraps modulo 2^AGG_WIDTH by construction.
  function automatic agg_row_t add_row(input agg_row_t a, input fm_wm_row_t b);
    agg_row_t r;
    for (int c = 0; c < WEIGHT_COLS; c++) begin
      r[c] = a[c] + AGG_WIDTH'(b[c]);
    end
    return r;
  endfunction

  function automatic agg_row_t widen_row(input fm_wm_row_t b);
    agg_row_t r;
    for (int c = 0; c < WEIGHT_COLS; c++) begin
      r[c] = AGG_WIDTH'(b[c]);
    end
    return r;
  endfunction

endpackage

// File: rtl/gcn_aggregate_argmax_if.sv
// rtl/gcn_aggregate_argmax_if.sv - read bus toward the FM x WM product memory and the COO edge store
// Purpose: groups the row/COO address and data signals.
// Ports (master = aggregate stage): read_row, enable_read, coo_address out; fm_wm_row_in, coo_in in.
interface gcn_aggregate_argmax_if;
  import gcn_pkg::*;

  logic [ROW_BW-1:0] read_row;
  logic              enable_read;
  fm_wm_row_t        fm_wm_row_in;
  logic [COO_BW-1:0] coo_address;
  coo_col_t          coo_in;

  modport master (
    output read_row, enable_read, coo_address,
    input  fm_wm_row_in, coo_in
  );

  modport slave (
    input  read_row, enable_read, coo_address,
    output fm_wm_row_in, coo_in
  );

endinterface

// File: rtl/gcn_aggregate_argmax_argmax_unit.sv
// rtl/gcn_aggregate_argmax_argmax_unit.sv - combinational argmax over one aggregated row
// Purpose: returns the column index of the largest unsigned element, lowest index on ties.
// Ports: row_i (agg_row_t) in; idx_o (MAX_ADDRESS_WIDTH) out.
module gcn_argmax_unit
  import gcn_pkg::*;
(
  input  agg_row_t                     row_i,
  output logic [MAX_ADDRESS_WIDTH-1:0] idx_o
);

  logic [AGG_WIDTH-1:0] best_val;

  always_comb begin
    idx_o    = '0;
    best_val = row_i[0];
    // Strict greater-than keeps the earliest column when values are equal.
    for (int c = 1; c < WEIGHT_COLS; c++) begin
      if (row_i[c] > best_val) begin
        best_val = row_i[c];
        idx_o    = MAX_ADDRESS_WIDTH'(c);
      end
    end
  end

endmodule

// File: rtl/gcn_aggregate_argmax.sv
// rtl/gcn_aggregate_argmax.sv - buffers FM x WM rows, aggregates over COO edges, publishes per-node argmax
// Purpose: LOAD rows, EDGE neighbour accumulation (self-loop via initial copy), ARGMAX one node per cycle.
// Ports: clk, reset (async active-low), start in; mem (master: row/COO read bus);
//        done out (level), max_addi_answer out (per-node class index).
module gcn_aggregate_argmax
  import gcn_pkg::*;
(
  input  logic                                               clk,
  input  logic                                               reset,
  input  logic                                               start,
  gcn_aggregate_argmax_if.master                             mem,
  output logic                                               done,
  output logic [0:FEATURE_ROWS-1][MAX_ADDRESS_WIDTH-1:0]     max_addi_answer
);

  state_t                                          state_q;
  logic [ROW_BW-1:0]                               read_row_q;
  logic                                            enable_read_q;
  logic [COO_BW-1:0]                               coo_address_q;
  logic [ROW_BW-1:0]                               node_q;
  logic                                            done_q;
  logic [0:FEATURE_ROWS-1][MAX_ADDRESS_WIDTH-1:0]  answer_q;
  fm_wm_row_t                                      fm_buf_q [FEATURE_ROWS];
  agg_row_t                                        agg_q    [FEATURE_ROWS];

  logic [ROW_BW-1:0]            s_idx, d_idx;
  logic                         edge_ok;
  fm_wm_row_t                   buf_s, buf_d;
  agg_row_t                     agg_sel;
  logic [MAX_ADDRESS_WIDTH-1:0] idx_d;

  assign mem.read_row    = read_row_q;
  assign mem.enable_read = enable_read_q;
  assign mem.coo_address = coo_address_q;
  assign done            = done_q;
  assign max_addi_answer = answer_q;

  // Edge decode: convert 1-based ids and fetch both endpoint rows.
  always_comb begin
    edge_ok = node_valid(mem.coo_in[0]) && node_valid(mem.coo_in[1]);
    s_idx   = ROW_BW'(mem.coo_in[0] - 1'b1);
    d_idx   = ROW_BW'(mem.coo_in[1] - 1'b1);
    buf_s   = '0;
    buf_d   = '0;
    agg_sel = '0;
    for (int n = 0; n < FEATURE_ROWS; n++) begin
      if (s_idx == ROW_BW'(n))  buf_s   = fm_buf_q[n];
      if (d_idx == ROW_BW'(n))  buf_d   = fm_buf_q[n];
      if (node_q == ROW_BW'(n)) agg_sel = agg_q[n];
    end
  end

  gcn_argmax_unit u_argmax (
    .row_i (agg_sel),
    .idx_o (idx_d)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      read_row_q    <= '0;
      enable_read_q <= 1'b0;
      coo_address_q <= '0;
      node_q        <= '0;
      done_q        <= 1'b0;
      answer_q      <= '0;
      for (int n = 0; n < FEATURE_ROWS; n++) begin
        fm_buf_q[n] <= '0;
        agg_q[n]    <= '0;
      end
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q       <= LOAD;
            read_row_q    <= '0;
            enable_read_q <= 1'b1;
            node_q        <= '0;
            done_q        <= 1'b0;
            for (int n = 0; n < FEATURE_ROWS; n++) agg_q[n] <= '0;
          end
        end
        LOAD: begin
          // Accumulator starts as a copy of the node's own row: that is the self-loop term.
          for (int n = 0; n < FEATURE_ROWS; n++) begin
            if (read_row_q == ROW_BW'(n)) begin
              fm_buf_q[n] <= mem.fm_wm_row_in;
              agg_q[n]    <= widen_row(mem.fm_wm_row_in);
            end
          end
          if (read_row_q == ROW_BW'(FEATURE_ROWS-1)) begin
            enable_read_q <= 1'b0;
            read_row_q    <= '0;
            coo_address_q <= '0;
            state_q       <= EDGE;
          end else begin
            read_row_q <= read_row_q + 1'b1;
          end
        end
        EDGE: begin
          // s==d lands only in the first branch, so a self-edge adds once.
          if (edge_ok) begin
            for (int n = 0; n < FEATURE_ROWS; n++) begin
              if (s_idx == ROW_BW'(n))      agg_q[n] <= add_row(agg_q[n], buf_d);
              else if (d_idx == ROW_BW'(n)) agg_q[n] <= add_row(agg_q[n], buf_s);
            end
          end
          if (coo_address_q == COO_BW'(COO_NUM_OF_COLS-1)) begin
            coo_address_q <= '0;
            node_q        <= '0;
            state_q       <= ARGMAX;
          end else begin
            coo_address_q <= coo_address_q + 1'b1;
          end
        end
        ARGMAX: begin
          for (int n = 0; n < FEATURE_ROWS; n++) begin
            if (node_q == ROW_BW'(n)) answer_q[n] <= idx_d;
          end
          if (node_q == ROW_BW'(FEATURE_ROWS-1)) begin
            node_q  <= '0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            node_q <= node_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
